// File: rtl/of_action_sync_buffer_pkg.sv
// Shared constants and types for the OpenFlow action sync buffer.
package of_action_sync_buffer_pkg;

    localparam int unsigned OF_DATA_WIDTH      = 64;
    localparam int unsigned OF_CTRL_WIDTH      = 8;
    localparam int unsigned OF_PKT_DEPTH_BITS  = 9;
    localparam int unsigned OF_ACT_DEPTH_BITS  = 3;
    localparam int unsigned OF_DST_PORT_POS    = 48;
    localparam int unsigned OF_DST_PORT_WIDTH  = 16;
    localparam int unsigned OF_IN_RDY_MARGIN   = 2;
    localparam logic [7:0]  OF_HDR_CTRL        = 8'hFF;
    localparam int unsigned OF_CNT_WIDTH       = 32;

    // Action queue entry layout: {drop, port_mask}, mask in the low bits.
    localparam int unsigned OF_ACTION_MASK_LSB = 0;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_SEND = 2'd1,
        OUT_DROP = 2'd2
    } out_state_t;

endpackage

// File: rtl/of_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty/free-count.
module of_sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_BITS:0]   o_free_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH_BITS:0] r_wr_ptr;
    logic [DEPTH_BITS:0] r_rd_ptr;
    logic                w_push;
    logic                w_pop;
    logic [DEPTH_BITS:0] w_used;

    assign w_push     = i_wr && !o_full;
    assign w_pop      = i_rd && !o_empty;
    assign w_used     = r_wr_ptr - r_rd_ptr;
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[DEPTH_BITS] != r_rd_ptr[DEPTH_BITS]) &&
                        (r_wr_ptr[DEPTH_BITS-1:0] == r_rd_ptr[DEPTH_BITS-1:0]);
    assign o_free_cnt = (DEPTH_BITS+1)'(DEPTH) - w_used;
    assign o_rd_data  = r_mem[r_rd_ptr[DEPTH_BITS-1:0]];

    // Storage array write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[DEPTH_BITS-1:0]] <= i_wr_data;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (DEPTH_BITS+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (DEPTH_BITS+1)'(1);
            end
        end
    end

endmodule

// File: rtl/of_action_sync_buffer.sv
// Holds datapath packets until their matcher action arrives, then forwards
// (rewriting the module-header dst-port field) or discards them in order.
module of_action_sync_buffer
    import of_action_sync_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = OF_DATA_WIDTH,
    parameter int unsigned CTRL_WIDTH     = OF_CTRL_WIDTH,
    parameter int unsigned PKT_DEPTH_BITS = OF_PKT_DEPTH_BITS,
    parameter int unsigned ACT_DEPTH_BITS = OF_ACT_DEPTH_BITS,
    parameter int unsigned DST_PORT_POS   = OF_DST_PORT_POS,
    parameter int unsigned DST_PORT_WIDTH = OF_DST_PORT_WIDTH,
    parameter int unsigned IN_RDY_MARGIN  = OF_IN_RDY_MARGIN,
    parameter logic [CTRL_WIDTH-1:0] HDR_CTRL = CTRL_WIDTH'(OF_HDR_CTRL)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [CTRL_WIDTH-1:0]     in_ctrl,
    input  logic                      in_wr,
    output logic                      in_rdy,
    input  logic                      act_valid,
    input  logic                      act_drop,
    input  logic [DST_PORT_WIDTH-1:0] act_port_mask,
    output logic                      act_rdy,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [CTRL_WIDTH-1:0]     out_ctrl,
    output logic                      out_wr,
    input  logic                      out_rdy,
    output logic [OF_CNT_WIDTH-1:0]   pkt_fwd_cnt,
    output logic [OF_CNT_WIDTH-1:0]   pkt_drop_cnt,
    output logic                      overflow
);

    localparam int unsigned PKT_WORD_WIDTH = DATA_WIDTH + CTRL_WIDTH + 1;
    localparam int unsigned ACT_WIDTH      = DST_PORT_WIDTH + 1;

    // Packet word storage
    logic                      r_seen_data;
    logic                      w_in_eop;
    logic                      w_pkt_push;
    logic                      w_pkt_pop;
    logic                      w_pkt_full;
    logic                      w_pkt_empty;
    logic [PKT_DEPTH_BITS:0]   w_pkt_free;
    logic [PKT_WORD_WIDTH-1:0] w_pkt_wr_word;
    logic [PKT_WORD_WIDTH-1:0] w_pkt_rd_word;
    logic [DATA_WIDTH-1:0]     w_head_data;
    logic [CTRL_WIDTH-1:0]     w_head_ctrl;
    logic                      w_head_eop;

    // Action queue
    logic                      w_act_push;
    logic                      w_act_pop;
    logic                      w_act_full;
    logic                      w_act_empty;
    logic [ACT_DEPTH_BITS:0]   w_act_free;
    logic [ACT_WIDTH-1:0]      w_act_wr_word;
    logic [ACT_WIDTH-1:0]      w_act_rd_word;
    logic [DST_PORT_WIDTH-1:0] w_act_mask;
    logic                      w_act_drop;

    // Output control
    out_state_t                r_state;
    out_state_t                w_state_nxt;
    logic [DST_PORT_WIDTH-1:0] r_mask;
    logic [DST_PORT_WIDTH-1:0] w_mask_nxt;
    logic                      w_out_wr;
    logic                      w_fwd_done;
    logic                      w_drop_done;
    logic [OF_CNT_WIDTH-1:0]   r_fwd_cnt;
    logic [OF_CNT_WIDTH-1:0]   r_drop_cnt;
    logic                      r_overflow;

    // EOP is the first non-zero ctrl word that follows at least one data word.
    assign w_in_eop      = (in_ctrl != '0) && r_seen_data;
    assign w_pkt_push    = in_wr && !w_pkt_full;
    assign w_pkt_wr_word = {w_in_eop, in_ctrl, in_data};
    assign w_head_data   = w_pkt_rd_word[DATA_WIDTH-1:0];
    assign w_head_ctrl   = w_pkt_rd_word[DATA_WIDTH +: CTRL_WIDTH];
    assign w_head_eop    = w_pkt_rd_word[PKT_WORD_WIDTH-1];

    // A zero mask with no drop request has nowhere to go, so it is stored as a drop.
    assign w_act_push    = act_valid && !w_act_full;
    assign w_act_wr_word = {act_drop || (act_port_mask == '0), act_port_mask};
    assign w_act_mask    = w_act_rd_word[OF_ACTION_MASK_LSB +: DST_PORT_WIDTH];
    assign w_act_drop    = w_act_rd_word[DST_PORT_WIDTH];

    assign in_rdy        = (w_pkt_free > (PKT_DEPTH_BITS+1)'(IN_RDY_MARGIN));
    assign act_rdy       = (w_act_free != '0);
    assign out_wr        = w_out_wr;
    assign pkt_fwd_cnt   = r_fwd_cnt;
    assign pkt_drop_cnt  = r_drop_cnt;
    assign overflow      = r_overflow;

    of_sync_fifo #(
        .WIDTH      (PKT_WORD_WIDTH),
        .DEPTH_BITS (PKT_DEPTH_BITS)
    ) u_pkt_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr       (in_wr),
        .i_wr_data  (w_pkt_wr_word),
        .i_rd       (w_pkt_pop),
        .o_rd_data  (w_pkt_rd_word),
        .o_full     (w_pkt_full),
        .o_empty    (w_pkt_empty),
        .o_free_cnt (w_pkt_free)
    );

    of_sync_fifo #(
        .WIDTH      (ACT_WIDTH),
        .DEPTH_BITS (ACT_DEPTH_BITS)
    ) u_act_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr       (w_act_push),
        .i_wr_data  (w_act_wr_word),
        .i_rd       (w_act_pop),
        .o_rd_data  (w_act_rd_word),
        .o_full     (w_act_full),
        .o_empty    (w_act_empty),
        .o_free_cnt (w_act_free)
    );

    // Track whether the current packet has seen a data (ctrl==0) word yet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seen_data <= 1'b0;
        end else if (w_pkt_push) begin
            r_seen_data <= (in_ctrl == '0);
        end
    end

    // Sticky flag for words lost because storage was full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (in_wr && w_pkt_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Output FSM state and latched port mask of the packet being sent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= OUT_IDLE;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    // Pair the head action with the head packet, then stream or discard it.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_act_pop   = 1'b0;
        w_pkt_pop   = 1'b0;
        w_out_wr    = 1'b0;
        w_fwd_done  = 1'b0;
        w_drop_done = 1'b0;
        case (r_state)
            OUT_IDLE: begin
                if (!w_act_empty && !w_pkt_empty) begin
                    w_act_pop   = 1'b1;
                    w_mask_nxt  = w_act_mask;
                    w_state_nxt = w_act_drop ? OUT_DROP : OUT_SEND;
                end
            end
            OUT_SEND: begin
                if (out_rdy && !w_pkt_empty) begin
                    w_out_wr  = 1'b1;
                    w_pkt_pop = 1'b1;
                    if (w_head_eop) begin
                        w_fwd_done  = 1'b1;
                        w_state_nxt = OUT_IDLE;
                    end
                end
            end
            OUT_DROP: begin
                if (!w_pkt_empty) begin
                    w_pkt_pop = 1'b1;
                    if (w_head_eop) begin
                        w_drop_done = 1'b1;
                        w_state_nxt = OUT_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = OUT_IDLE;
            end
        endcase
    end

    // Present the storage head; module-header words carry the action's port mask.
    always_comb begin
        out_data = '0;
        out_ctrl = '0;
        if (!w_pkt_empty) begin
            out_data = w_head_data;
            out_ctrl = w_head_ctrl;
            if ((r_state == OUT_SEND) && (w_head_ctrl == HDR_CTRL)) begin
                out_data[DST_PORT_POS +: DST_PORT_WIDTH] = r_mask;
            end
        end
    end

    // Forward/drop statistics, bumped on the EOP word of each packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fwd_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_fwd_done) begin
                r_fwd_cnt <= r_fwd_cnt + OF_CNT_WIDTH'(1);
            end
            if (w_drop_done) begin
                r_drop_cnt <= r_drop_cnt + OF_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_of_action_sync_buffer.sv
// Scoreboard bench for of_action_sync_buffer: packets and actions are paired
// in arrival order by a queue model; a monitor checks every emitted word.
module tb_of_action_sync_buffer;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
    } word_t;

    typedef struct packed {
        logic        drop;
        logic [15:0] mask;
    } act_t;

    logic        clk;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic        act_valid;
    logic        act_drop;
    logic [15:0] act_port_mask;
    logic        act_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [31:0] pkt_fwd_cnt;
    logic [31:0] pkt_drop_cnt;
    logic        overflow;

    of_action_sync_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_ctrl       (in_ctrl),
        .in_wr         (in_wr),
        .in_rdy        (in_rdy),
        .act_valid     (act_valid),
        .act_drop      (act_drop),
        .act_port_mask (act_port_mask),
        .act_rdy       (act_rdy),
        .out_data      (out_data),
        .out_ctrl      (out_ctrl),
        .out_wr        (out_wr),
        .out_rdy       (out_rdy),
        .pkt_fwd_cnt   (pkt_fwd_cnt),
        .pkt_drop_cnt  (pkt_drop_cnt),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random

    // Reference model: packets as word lists, actions in order, expected output.
    word_t       mdl_word_q[$];
    int          mdl_len_q[$];
    act_t        mdl_act_q[$];
    word_t       exp_q[$];
    int unsigned exp_fwd;
    int unsigned exp_drop;
    word_t       mon_exp;

    function automatic void check(string name, logic [63:0] got, logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endfunction

    // Pair queued packets with queued actions; forwarded packets get the mask in every header word.
    function automatic void model_pair();
        int    n;
        act_t  a;
        word_t w;
        bit    fwd;
        while (mdl_len_q.size() > 0 && mdl_act_q.size() > 0) begin
            n   = mdl_len_q.pop_front();
            a   = mdl_act_q.pop_front();
            fwd = !a.drop && (a.mask != 16'h0);
            for (int i = 0; i < n; i++) begin
                w = mdl_word_q.pop_front();
                if (fwd) begin
                    if (w.c == 8'hFF) w.d[63:48] = a.mask;
                    exp_q.push_back(w);
                end
            end
            if (fwd) exp_fwd++;
            else     exp_drop++;
        end
    endfunction

    function automatic void model_clear();
        mdl_word_q.delete();
        mdl_len_q.delete();
        mdl_act_q.delete();
        exp_q.delete();
        exp_fwd  = 0;
        exp_drop = 0;
    endfunction

    // Downstream ready pattern.
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_rdy = ~out_rdy;
                2:       out_rdy = ($urandom_range(0, 3) != 0);
                default: out_rdy = 1'b1;
            endcase
        end
    end

    // Monitor: every emitted word must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_wr) begin
                check("out_wr_needs_out_rdy", 64'(out_rdy), 64'(1));
                if (exp_q.size() == 0) begin
                    check("unexpected_out_wr", 64'(out_wr), 64'(0));
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_data", out_data, mon_exp.d);
                    check("out_ctrl", 64'(out_ctrl), 64'(mon_exp.c));
                end
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_word(input word_t w);
        int guard;
        guard = 0;
        while (!in_rdy && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 3000) check("in_rdy_timeout", 64'(in_rdy), 64'(1));
        in_data = w.d;
        in_ctrl = w.c;
        in_wr   = 1'b1;
        @(posedge clk);
        #1;
        in_wr   = 1'b0;
    endtask

    // Header (ctrl FF), ndata words with ctrl 0, last word with last_ctrl.
    task automatic send_pkt(input int ndata, input logic [7:0] last_ctrl, input bit rnd);
        word_t w[$];
        word_t t;
        t.d = rnd ? {$urandom(), $urandom()} : 64'hDEAD_BEEF_CAFE_F00D;
        t.c = 8'hFF;
        w.push_back(t);
        for (int i = 0; i < ndata; i++) begin
            t.d = rnd ? {$urandom(), $urandom()} : (64'hA5A5_0000_0000_0000 | 64'(i));
            t.c = 8'h00;
            w.push_back(t);
        end
        t.d = rnd ? {$urandom(), $urandom()} : 64'h0123_4567_89AB_CDEF;
        t.c = last_ctrl;
        w.push_back(t);
        foreach (w[i]) mdl_word_q.push_back(w[i]);
        mdl_len_q.push_back(w.size());
        model_pair();
        foreach (w[i]) begin
            drive_word(w[i]);
            if (rnd && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_act(input bit drop, input logic [15:0] mask);
        int   guard;
        act_t a;
        a.drop = drop;
        a.mask = mask;
        mdl_act_q.push_back(a);
        model_pair();
        guard = 0;
        while (!act_rdy && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 3000) check("act_rdy_timeout", 64'(act_rdy), 64'(1));
        act_valid     = 1'b1;
        act_drop      = drop;
        act_port_mask = mask;
        @(posedge clk);
        #1;
        act_valid     = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_wr     = 1'b0;
        act_valid = 1'b0;
        rdy_mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_wr"},   64'(out_wr),       64'(0));
        check({tag, "_out_data"}, out_data,          64'(0));
        check({tag, "_out_ctrl"}, 64'(out_ctrl),     64'(0));
        check({tag, "_fwd_cnt"},  64'(pkt_fwd_cnt),  64'(0));
        check({tag, "_drop_cnt"}, 64'(pkt_drop_cnt), 64'(0));
        check({tag, "_overflow"}, 64'(overflow),     64'(0));
        check({tag, "_in_rdy"},   64'(in_rdy),       64'(1));
        check({tag, "_act_rdy"},  64'(act_rdy),      64'(1));
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
        repeat (200) @(posedge clk);
        #1;
        check({tag, "_fwd_cnt"},  64'(pkt_fwd_cnt),  64'(exp_fwd));
        check({tag, "_drop_cnt"}, 64'(pkt_drop_cnt), 64'(exp_drop));
    endtask

    initial begin
        reset         = 1'b1;
        in_data       = '0;
        in_ctrl       = '0;
        in_wr         = 1'b0;
        act_valid     = 1'b0;
        act_drop      = 1'b0;
        act_port_mask = '0;
        model_clear();

        // 1: forward a 4-word packet with mask 0004
        do_reset();
        check_reset_state("reset");
        fork
            send_pkt(2, 8'h08, 1'b0);
            send_act(1'b0, 16'h0004);
        join
        drain("t1");

        // 2: same packet dropped
        do_reset();
        fork
            send_pkt(2, 8'h08, 1'b0);
            send_act(1'b1, 16'h0004);
        join
        drain("t2");

        // 3: zero mask without drop is a drop
        do_reset();
        fork
            send_pkt(2, 8'h08, 1'b0);
            send_act(1'b0, 16'h0000);
        join
        drain("t3");

        // 4: three stored packets, then fwd/drop/fwd
        do_reset();
        send_pkt(1, 8'h01, 1'b1);
        send_pkt(3, 8'h80, 1'b1);
        send_pkt(2, 8'h0F, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        send_act(1'b0, 16'h0001);
        send_act(1'b1, 16'h0002);
        send_act(1'b0, 16'h8000);
        drain("t4");

        // 5: downstream ready toggling during SEND
        do_reset();
        rdy_mode = 1;
        fork
            send_pkt(10, 8'h04, 1'b1);
            send_act(1'b0, 16'h0030);
        join
        drain("t5");
        rdy_mode = 0;

        // 6: fill storage, overflow, then reset mid-packet
        do_reset();
        for (int i = 0; i < 513; i++) begin
            in_data = {32'hF111_0000, 32'(i)};
            in_ctrl = (i == 0) ? 8'hFF : 8'h00;
            in_wr   = 1'b1;
            @(posedge clk);
            #1;
            if (i == 508) check("t6_in_rdy_free3", 64'(in_rdy), 64'(1));
            if (i == 509) check("t6_in_rdy_free2", 64'(in_rdy), 64'(0));
            if (i == 511) check("t6_no_overflow_at_full", 64'(overflow), 64'(0));
        end
        in_wr = 1'b0;
        check("t6_overflow_set", 64'(overflow), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        check("t6_overflow_sticky", 64'(overflow), 64'(1));
        check("t6_no_out_without_action", 64'(out_wr), 64'(0));
        do_reset();
        check_reset_state("t6_midpkt_reset");
        fork
            send_pkt(3, 8'h02, 1'b1);
            send_act(1'b0, 16'h0100);
        join
        drain("t6");

        // 7: randomized traffic with random ready, drops and zero masks
        do_reset();
        rdy_mode = 2;
        fork
            begin
                for (int p = 0; p < 25; p++) begin
                    send_pkt($urandom_range(1, 12), 8'($urandom_range(1, 254)), 1'b1);
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    #1;
                end
            end
            begin
                for (int a = 0; a < 25; a++) begin
                    case ($urandom_range(0, 9))
                        0, 1:    send_act(1'b1, 16'($urandom()));
                        2:       send_act(1'b0, 16'h0000);
                        default: send_act(1'b0, 16'(16'h0001 << $urandom_range(0, 15)));
                    endcase
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    #1;
                end
            end
        join
        drain("t7");
        rdy_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
